// File: rtl/kmac_bytepad_decoder.sv
// Parses bytepad(encode_string(S), w) framing: checks w, decodes len(S), streams S, eats pad.
// Build option: define KMAC_PAD_CHECK_EN to require every pad byte to be 0x00.
module kmac_bytepad_decoder #(
  parameter int unsigned RATE_BYTES    = 136,
  parameter int unsigned LEN_BITS      = 16,
  parameter int unsigned MAX_ENC_BYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  output logic [7:0]          out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [LEN_BITS-1:0] str_bit_len,
  output logic                busy,
  output logic                done,
  output logic [2:0]          err_code
);

  localparam int unsigned CNT_W = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;
  localparam int unsigned ACC_W = 8 * MAX_ENC_BYTES;
  localparam int unsigned CMP_W = (ACC_W > 17) ? ACC_W : 17;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_BAD_W   = 3'd1;
  localparam logic [2:0] ERR_BAD_ENC = 3'd2;
  localparam logic [2:0] ERR_ALIGN   = 3'd3;
  localparam logic [2:0] ERR_PAD     = 3'd4;
  localparam logic [2:0] ERR_TRUNC   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_WN, S_WV, S_LN, S_LV, S_STR, S_PAD, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bcnt_q, bcnt_d, bcnt_nxt;
  logic [7:0]          rem_q, rem_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_nxt;
  logic [LEN_BITS-1:0] scnt_q, scnt_d;
  logic [LEN_BITS-1:0] len_q, len_d, len_val;
  logic [2:0]          err_q, err_d;
  logic                hs, n_bad, len_ovf, fin_ok;

  assign hs       = in_valid && in_ready;
  assign bcnt_nxt = (bcnt_q == CNT_W'(RATE_BYTES - 1)) ? '0 : bcnt_q + CNT_W'(1);
  assign acc_nxt  = (acc_q << 8) | ACC_W'(in_data);
  assign n_bad    = (in_data == 8'd0) || (32'(in_data) > MAX_ENC_BYTES);
  assign len_ovf  = (CMP_W'(acc_nxt) >> LEN_BITS) != '0;
  assign len_val  = LEN_BITS'(acc_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      scnt_q  <= '0;
      len_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      scnt_q  <= scnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // fin_ok marks the byte that legally closes the frame on the w boundary
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    scnt_d  = scnt_q;
    len_d   = len_q;
    err_d   = err_q;
    fin_ok  = 1'b0;
    if (hs) bcnt_d = bcnt_nxt;
    case (state_q)
      S_IDLE: if (start) begin
        bcnt_d  = '0;
        len_d   = '0;
        err_d   = ERR_OK;
        state_d = S_WN;
      end
      S_WN, S_LN: if (hs) begin
        if (n_bad) begin
          err_d   = ERR_BAD_ENC;
          state_d = S_FIN;
        end else begin
          rem_d   = in_data;
          acc_d   = '0;
          state_d = (state_q == S_WN) ? S_WV : S_LV;
        end
      end
      S_WV: if (hs) begin
        acc_d = acc_nxt;
        rem_d = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          if (CMP_W'(acc_nxt) != CMP_W'(RATE_BYTES)) begin
            err_d   = ERR_BAD_W;
            state_d = S_FIN;
          end else begin
            state_d = S_LN;
          end
        end
      end
      S_LV: if (hs) begin
        acc_d = acc_nxt;
        rem_d = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          if (len_ovf) begin
            err_d   = ERR_BAD_ENC;
            state_d = S_FIN;
          end else if (acc_nxt[2:0] != 3'd0) begin
            err_d   = ERR_ALIGN;
            state_d = S_FIN;
          end else begin
            len_d  = len_val;
            scnt_d = len_val >> 3;
            if (len_val != '0) begin
              state_d = S_STR;
            end else if (bcnt_nxt == '0) begin
              fin_ok  = 1'b1;
              state_d = S_FIN;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end
      S_STR: if (hs) begin
        scnt_d = scnt_q - LEN_BITS'(1);
        if (scnt_q == LEN_BITS'(1)) begin
          if (bcnt_nxt == '0) begin
            fin_ok  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: if (hs) begin
        if (bcnt_nxt == '0) begin
          fin_ok  = 1'b1;
          state_d = S_FIN;
        end
`ifdef KMAC_PAD_CHECK_EN
        if (in_data != 8'd0) begin
          err_d   = ERR_PAD;
          state_d = S_FIN;
        end
`endif
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A premature end of frame overrides whatever else this byte decided
    if (hs && in_last && !fin_ok) begin
      err_d   = ERR_TRUNC;
      len_d   = len_q;
      state_d = S_FIN;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_last  = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    case (state_q)
      S_WN, S_WV, S_LN, S_LV, S_PAD: in_ready = 1'b1;
      S_STR: begin
        out_valid = in_valid;
        out_data  = in_data;
        out_last  = (scnt_q == LEN_BITS'(1));
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign str_bit_len = len_q;
  assign err_code    = err_q;

endmodule

// File: doc/kmac_bytepad_decoder.md
Name: kmac_bytepad_decoder

Overview:
Byte-stream parser that undoes the NIST SP 800-185 `bytepad(encode_string(S), w)` framing produced by the KMAC key/customization padding path. It performs these steps in order:
- validates the `left_encode(w)` header;
- decodes the `left_encode(bitlen)` prefix and streams S out with valid/ready;
- consumes the zero padding up to the w-byte boundary;
- reports the decoded length and status.

It is used for loopback checking of the padding pipeline and for parsing externally supplied pre-padded KMAC key blocks.

Parameters:
- `RATE_BYTES`, 136, expected w in bytes (cSHAKE rate / 8); allowed range 1..65535.
- `LEN_BITS`, 16, width of the decoded string bit-length.
- `MAX_ENC_BYTES`, 2, maximum accepted n in a `left_encode` prefix; ceil(`LEN_BITS`/8) must be ≤ `MAX_ENC_BYTES`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: one clock, asynchronous, active-high.
- `start`  in  1  one-cycle pulse that arms the parser; ignored unless in IDLE.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_last`  in  1  marks the final byte of the upstream frame.
- `in_ready`  out  1  decoder accepts `in_data`.
- `out_valid`  out  1  string byte valid.
- `out_data`  out  8  string byte S[i].
- `out_last`  out  1  marks the final string byte.
- `out_ready`  in  1  downstream accepts.
- `str_bit_len`  out  `LEN_BITS`  decoded bit length of S; registered, held until the next `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err_code`  out  3  0=ok, 1=BAD_W, 2=BAD_ENC, 3=LEN_ALIGN, 4=PAD_NONZERO, 5=TRUNCATED; valid with `done`, held until the next `start`.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0.
- A byte is consumed when `in_valid && in_ready`. The byte counter `bcnt` counts consumed bytes modulo `RATE_BYTES` (wraps to 0 at `RATE_BYTES`).
- States and transitions:
  - IDLE: `in_ready`=0. On `start`: clear `bcnt`, `str_bit_len`, `err_code`; go to W_N.
  - W_N: `in_ready`=1. Byte n: if n==0 or n>`MAX_ENC_BYTES`, error BAD_ENC; otherwise load the remaining-byte count and go to W_V.
  - W_V: `in_ready`=1. Shift in n bytes, big-endian. After the last byte, if the value ≠ `RATE_BYTES`, error BAD_W; otherwise go to L_N.
  - L_N / L_V: same n-byte decode as W_N / W_V into a `LEN_BITS` accumulator.
    - n out of range → BAD_ENC.
    - Decoded value with low 3 bits ≠0 → LEN_ALIGN.
    - Otherwise latch `str_bit_len`. If length==0, go to PAD; otherwise go to STR with a byte down-counter of length/8.
  - STR: pure pass-through, zero latency, no buffering.
    - `out_valid`=`in_valid`, `out_data`=`in_data`, `in_ready`=`out_ready`.
    - `out_last`=1 when the down-counter ==1.
    - Each handshake decrements the counter; the last one goes to PAD.
  - PAD: `in_ready`=1.
    - If `bcnt`==0 on entry, or after the final consumed byte, go to FIN.
    - Each pad byte is checked per the optional feature below.
  - FIN: `done`=1 for one cycle with the latched `err_code`; go to IDLE.
- Errors: on any error, latch `err_code`, drop `in_ready` the next cycle, go to FIN, then return to IDLE. Bytes remaining in the frame are not consumed; upstream flushes them.
- TRUNCATED: a byte is consumed with `in_last`=1 in any state before the PAD→FIN condition is met. The one exception is the byte that completes the pad boundary, which is legal with `in_last`=1. TRUNCATED takes priority over other errors detected on the same byte.
- Bytes arriving after FIN are not consumed.
- `start` while busy is ignored.
- Latency: `done` asserts exactly 1 cycle after the handshake of the final pad byte. If there is no padding, it asserts 1 cycle after the final string/length byte.
- Length accumulator overflow: a decoded value wider than `LEN_BITS` (nonzero bits shifted out) reports BAD_ENC.
- `rst` asserted mid-frame: immediate return to IDLE; all outputs 0; no `done` pulse.

Optional Feature:
- Macro: `KMAC_PAD_CHECK_EN`.
- Defined: every PAD byte must be 0x00. The first nonzero pad byte causes PAD_NONZERO and the transition to FIN.
- Undefined: pad bytes are consumed and discarded unchecked; PAD_NONZERO is never reported.
- Boundary tracking and TRUNCATED detection are identical in both builds.

Test Plan:
- Nominal: frame 01 88, 01 20, 4B 4D 41 43, then 128×00 with `in_last` on byte 136, `out_ready`=1 → 4 out beats 4B 4D 41 43 with `out_last` on 43; `done` 1 cycle after byte 136; `str_bit_len`=32; `err_code`=0.
- Empty string: 01 88 01 00 + 132×00 → no out beats; `str_bit_len`=0; `err_code`=0; `done` after byte 136.
- Header errors:
  - 01 A8 … → `err_code`=1, `done` 1 cycle after byte 2.
  - First byte 00 → `err_code`=2.
  - Length 01 21 → `err_code`=3.
- Backpressure: nominal frame with `out_ready` low for 3 cycles after beat 2 → `in_ready` low for the same 3 cycles; bytes delivered in order with no loss or duplication.
- Pad faults:
  - Byte 100 = 0x01: with `KMAC_PAD_CHECK_EN` → `err_code`=4 at byte 100; without → `err_code`=0 after byte 136.
  - `in_last` on byte 50 → `err_code`=5.
- Reset: `rst` pulse during STR after beat 2 → all outputs 0 and IDLE next cycle; a subsequent `start` plus the nominal frame passes cleanly.
